// File: rtl/uart_mult_pkg.sv
// Shared types and sizing for the UART multiply engine and its shift-add datapath.
package uart_mult_pkg;

  localparam int unsigned OP_WIDTH   = 8;
  localparam int unsigned RES_WIDTH  = 16;
  localparam int unsigned MULT_ITERS = 8;
  localparam int unsigned ITER_W     = $clog2(MULT_ITERS);

  typedef enum logic [2:0] {
    StIdle,
    StWaitB,
    StMult,
    StSendHi,
    StWaitHi,
    StSendLo,
    StWaitLo
  } state_e;

endpackage

// File: rtl/shift_add_mult8.sv
// Unsigned 8x8 shift-add multiplier, one iteration per cycle. done_o is high during the final
// iteration and product_o carries that iteration's sum, so the caller can latch it on the same edge.
module shift_add_mult8
  import uart_mult_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [OP_WIDTH-1:0]  a_i,
  input  logic [OP_WIDTH-1:0]  b_i,
  output logic                 done_o,
  output logic [RES_WIDTH-1:0] product_o
);

  logic [RES_WIDTH-1:0] mcand_q, mcand_d;
  logic [RES_WIDTH-1:0] acc_q, acc_d;
  logic [RES_WIDTH-1:0] acc_sum;
  logic [OP_WIDTH-1:0]  mplier_q, mplier_d;
  logic [ITER_W-1:0]    cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 last_iter;

  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = (cnt_q == ITER_W'(MULT_ITERS - 1));
  assign done_o    = run_q && last_iter;
  assign product_o = acc_sum;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = {{(RES_WIDTH - OP_WIDTH){1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_iter) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/uart_mult_engine.sv
// Collects two operand bytes from UART RX, multiplies them, and returns the 16-bit product
// to UART TX high byte first.
module uart_mult_engine
  import uart_mult_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_WIDTH-1:0]  rx_data,
  input  logic                 rx_valid,
  input  logic                 tx_ready,
  output logic [OP_WIDTH-1:0]  tx_data,
  output logic                 tx_start,
  output logic [RES_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned ToW = 20;

  state_e               state_q, state_d;
  logic [OP_WIDTH-1:0]  a_q, a_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic [OP_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [RES_WIDTH-1:0] result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 mult_start, mult_done;
  logic [RES_WIDTH-1:0] mult_product;

  shift_add_mult8 u_mult (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (mult_start),
    .a_i       (a_q),
    .b_i       (rx_data),
    .done_o    (mult_done),
    .product_o (mult_product)
  );

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    to_cnt_d       = to_cnt_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    mult_start     = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_valid) begin
          a_d      = rx_data;
          to_cnt_d = '0;
          state_d  = StWaitB;
        end
      end
      StWaitB: begin
        // A byte arriving on the expiry cycle still wins over the timeout.
        if (rx_valid) begin
          mult_start = 1'b1;
          state_d    = StMult;
        end else if (to_cnt_q == ToW'(RX_TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StMult: begin
        if (mult_done) begin
          result_d       = mult_product;
          result_valid_d = 1'b1;
          state_d        = StSendHi;
        end
      end
      StSendHi: begin
        if (tx_ready) begin
          tx_data_d  = result_q[RES_WIDTH-1:OP_WIDTH];
          tx_start_d = 1'b1;
          state_d    = StWaitHi;
        end
      end
      StWaitHi: begin
        if (!tx_ready) state_d = StSendLo;
      end
      StSendLo: begin
        if (tx_ready) begin
          tx_data_d  = result_q[OP_WIDTH-1:0];
          tx_start_d = 1'b1;
          state_d    = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d    = !(state_d inside {StIdle, StWaitB});
    overrun_d = overrun_q | (rx_valid & busy_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      a_q            <= '0;
      to_cnt_q       <= '0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      to_cnt_q       <= to_cnt_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_mult_engine.sv
// Scoreboard bench for uart_mult_engine with a small UART TX handshake model.
module tb_uart_mult_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int tx_starts = 0;
  int gap = 0;
  bit tx_hold = 1'b0;
  bit tx_accept;
  bit prev_txs = 1'b0;
  bit prev_rv = 1'b0;

  logic [15:0] res_q[$];
  logic [7:0]  txb_q[$];

  always #5 clk = ~clk;

  uart_mult_engine #(.RX_TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART TX model: ready drops the cycle after a start is accepted, returns 3 cycles later.
  always @(posedge clk) begin
    tx_accept = tx_start;
    #1;
    if (tx_accept) begin
      tx_ready = 1'b0;
      gap = 3;
    end else if (gap > 0) begin
      gap--;
      if (gap == 0 && !tx_hold) tx_ready = 1'b1;
    end else begin
      tx_ready = !tx_hold;
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin
      tx_starts++;
      check_val("tx_ready_at_start", 32'(tx_ready), 32'd1);
      check_val("tx_start_pulse", 32'(prev_txs), 32'd0);
      if (txb_q.size() == 0) check_val("tx_extra", 32'(tx_start), 32'd0);
      else check_val("tx_byte", 32'(tx_data), 32'(txb_q.pop_front()));
    end
    if (result_valid) begin
      check_val("rv_pulse", 32'(prev_rv), 32'd0);
      if (res_q.size() == 0) check_val("rv_extra", 32'(result_valid), 32'd0);
      else check_val("result", 32'(result), 32'(res_q.pop_front()));
    end
    prev_txs = tx_start;
    prev_rv  = result_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap_cyc,
                           input bit push_lo);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    res_q.push_back(p);
    txb_q.push_back(p[15:8]);
    if (push_lo) txb_q.push_back(p[7:0]);
    send_byte(a);
    repeat (gap_cyc) @(posedge clk);
    send_byte(b);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((res_q.size() != 0 || txb_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(n >= 300), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    // Reset with random inputs.
    rx_valid = 1'($urandom);
    rx_data  = 8'($urandom);
    repeat (2) begin
      @(posedge clk);
      #1;
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
    end
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_result_valid", 32'(result_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    repeat (20) @(negedge clk);
    check_val("rst_no_tx", 32'(tx_starts), 32'd0);

    // Basic product with latency measurement.
    send_pair(8'h0C, 8'h0D, 0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 50);
    check_val("rv_latency", 32'(n), 32'd9);
    while (!tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_latency", 32'(n), 32'd10);
    wait_done("basic_done");
    check_val("result_hold", 32'(result), 32'h009C);

    send_pair(8'hFF, 8'hFF, 0, 1'b1);
    wait_done("full_scale_done");
    send_pair(8'h00, 8'hA5, 2, 1'b1);
    wait_done("zero_done");
    for (int i = 0; i < 4; i++) begin
      send_pair(8'($urandom), 8'($urandom), i, 1'b1);
      wait_done("random_done");
    end
    check_val("no_overrun_yet", 32'(overrun), 32'd0);

    // Overrun: third byte lands during MULT and is dropped.
    send_pair(8'h03, 8'h04, 0, 1'b1);
    send_byte(8'h77);
    wait_done("overrun_done");
    check_val("overrun_set", 32'(overrun), 32'd1);
    send_pair(8'h02, 8'h02, 0, 1'b1);
    wait_done("after_overrun_done");
    check_val("overrun_sticky", 32'(overrun), 32'd1);

    // Timeout: lone A discarded, then B exactly on the expiry cycle.
    send_byte(8'h05);
    repeat (20) @(posedge clk);
    send_pair(8'h03, 8'h04, 0, 1'b1);
    wait_done("timeout_done");
    send_pair(8'h06, 8'h07, 14, 1'b1);
    wait_done("expiry_b_done");
    // One cycle past expiry the byte becomes a new A, which then times out too.
    send_byte(8'h09);
    repeat (15) @(posedge clk);
    send_byte(8'h08);
    repeat (20) @(negedge clk);
    check_val("late_b_idle", 32'(busy), 32'd0);
    check_val("late_b_result", 32'(result), 32'h002A);

    // Back-pressure: ready held low, no start issued.
    tx_hold = 1'b1;
    repeat (2) @(posedge clk);
    send_pair(8'h12, 8'h34, 0, 1'b0);
    repeat (12) @(negedge clk);
    check_val("bp_result_seen", 32'(res_q.size()), 32'd0);
    s0 = tx_starts;
    repeat (100) @(negedge clk);
    check_val("bp_no_start", 32'(tx_starts - s0), 32'd0);
    check_val("bp_busy", 32'(busy), 32'd1);
    tx_hold = 1'b0;
    n = 0;
    while (txb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("bp_hi_sent", 32'(txb_q.size()), 32'd0);
    // Now in WAIT_HI: reset abandons the low byte.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    s0 = tx_starts;
    @(negedge clk);
    check_val("rst_wait_hi_busy", 32'(busy), 32'd0);
    check_val("rst_wait_hi_result", 32'(result), 32'd0);
    repeat (20) @(negedge clk);
    check_val("rst_wait_hi_no_lo", 32'(tx_starts - s0), 32'd0);

    check_val("res_queue_empty", 32'(res_q.size()), 32'd0);
    check_val("tx_queue_empty", 32'(txb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
